// File: rtl/sifive_scope_dcache_pkg.sv
// ============================================================================
// sifive_scope_dcache_pkg : command encodings, tracked-command test, entry record
// Rev 1.0
// ============================================================================
`default_nettype none

package sifive_scope_dcache_pkg;

  localparam logic [4:0] CMD_XRD     = 5'b00000;
  localparam logic [4:0] CMD_XA_SWAP = 5'b00100;
  localparam logic [4:0] CMD_XLR     = 5'b00110;
  localparam logic [4:0] CMD_XSC     = 5'b00111;
  // All AMOs share the 01xxx prefix.
  localparam logic [1:0] CMD_AMO_HI  = 2'b01;

  // Latency is kept at full word width; only the low LAT_W bits are reported.
  typedef struct packed {
    logic [31:0] addr;
    logic [6:0]  id;
    logic [4:0]  cmd;
    logic        is_signed;
    logic [1:0]  size;
    logic [31:0] latency;
  } entry_t;

  function automatic logic is_tracked(input logic [4:0] cmd);
    return (cmd == CMD_XRD) || (cmd == CMD_XA_SWAP) || (cmd == CMD_XLR) ||
           (cmd == CMD_XSC) || (cmd[4:3] == CMD_AMO_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sifive_scope_load_align.sv
// ============================================================================
// sifive_scope_load_align : lane-aligns a response word and sign/zero-extends it
// Rev 1.0
// ============================================================================
`default_nettype none

module sifive_scope_load_align (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] data,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = data >> {addr_lo, 3'b000};
    case (size)
      2'd0:    result = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      2'd1:    result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sifive_scope_dcache_resp_tracker.sv
// ============================================================================
// sifive_scope_dcache_resp_tracker : matches dcache responses to tracked requests
// Optional per-entry latency counters: SIFIVE_SCOPE_DCACHE_LATENCY_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module sifive_scope_dcache_resp_tracker
  import sifive_scope_dcache_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int LAT_W   = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [31:0]                  req_addr,
  input  logic [6:0]                   req_id,
  input  logic [4:0]                   req_cmd,
  input  logic                         req_signed,
  input  logic [1:0]                   req_size,
  input  logic                         resp_valid,
  input  logic [6:0]                   resp_id,
  input  logic [31:0]                  resp_data,
  output logic                         out_valid,
  output logic [31:0]                  out_addr,
  output logic [4:0]                   out_cmd,
  output logic [31:0]                  out_data,
  output logic [LAT_W-1:0]             out_latency,
  output logic [$clog2(ENTRIES+1)-1:0] outstanding,
  output logic                         err_overflow,
  output logic                         err_orphan,
  output logic                         err_dup
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES+1);

  entry_t             ents [ENTRIES];
  logic [ENTRIES-1:0] pend;

  logic               tracked, hit, dup, has_free, wr;
  logic [IDX_W-1:0]   hit_idx, dup_idx, free_idx, wr_idx;
  logic [ENTRIES-1:0] pend_next;
  logic [CNT_W-1:0]   cnt_next;
  entry_t             sel;
  logic [31:0]        aligned;
  logic               lat_unused;

  // Searches only look at the pre-cycle table, so nothing freed this cycle is reused.
  always_comb begin
    tracked  = req_valid && is_tracked(req_cmd);
    hit      = 1'b0;
    dup      = 1'b0;
    has_free = 1'b0;
    hit_idx  = '0;
    dup_idx  = '0;
    free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (resp_valid && pend[i] && ents[i].id == resp_id) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (tracked && pend[i] && ents[i].id == req_id) begin
        dup     = 1'b1;
        dup_idx = IDX_W'(i);
      end
      if (!pend[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    wr     = tracked && (dup || has_free);
    wr_idx = dup ? dup_idx : free_idx;

    pend_next = pend;
    if (hit) pend_next[hit_idx] = 1'b0;
    if (wr)  pend_next[wr_idx]  = 1'b1;

    cnt_next = '0;
    for (int i = 0; i < ENTRIES; i++) cnt_next = cnt_next + CNT_W'(pend_next[i]);
  end

  assign sel        = ents[hit_idx];
  assign lat_unused = ^sel.latency;

  sifive_scope_load_align u_align (
    .addr_lo   (sel.addr[1:0]),
    .size      (sel.size),
    .is_signed (sel.is_signed),
    .data      (resp_data),
    .result    (aligned)
  );

`ifdef SIFIVE_SCOPE_DCACHE_LATENCY_EN
  localparam logic [31:0] LAT_MAX = (LAT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LAT_W) - 32'd1);
  // The stored count already reflects the current cycle: the allocation cycle is 0.
  localparam logic [31:0] LAT_INIT = 32'd1;
`else
  localparam logic [31:0] LAT_INIT = 32'd0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pend         <= '0;
      outstanding  <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_cmd      <= '0;
      out_data     <= '0;
      out_latency  <= '0;
      err_overflow <= 1'b0;
      err_orphan   <= 1'b0;
      err_dup      <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) ents[i] <= '0;
    end else begin
      pend        <= pend_next;
      outstanding <= cnt_next;
      out_valid   <= hit;
      if (hit) begin
        out_addr <= sel.addr;
        out_cmd  <= sel.cmd;
        out_data <= aligned;
`ifdef SIFIVE_SCOPE_DCACHE_LATENCY_EN
        out_latency <= sel.latency[LAT_W-1:0];
`else
        out_latency <= '0;
`endif
      end
      if (tracked && !wr)                err_overflow <= 1'b1;
      if (resp_valid && !hit)            err_orphan   <= 1'b1;
      if (dup)                           err_dup      <= 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr && wr_idx == IDX_W'(i)) begin
          ents[i] <= '{addr: req_addr, id: req_id, cmd: req_cmd, is_signed: req_signed,
                       size: req_size, latency: LAT_INIT};
        end
`ifdef SIFIVE_SCOPE_DCACHE_LATENCY_EN
        else if (pend[i] && ents[i].latency != LAT_MAX) begin
          ents[i].latency <= ents[i].latency + 32'd1;
        end
`endif
      end
    end
  end

endmodule

`default_nettype wire
